// File: rtl/scramble_decoder.sv
// Purpose: inverts the lock machine's triplet scrambler, restoring (r0,r1,r2) order from {outsel,regsel}.
// Latency: 1 cycle from input transfer to out_valid when the output buffer is empty.
// Backpressure: 2-entry output buffer (main + skid); in_ready is a flop (!skid_full), never combinational from out_ready.
module scramble_decoder #(
    parameter int W  = 5,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_outsel,
    input  logic [1:0]    in_regsel,
    input  logic [W-1:0]  in_d0,
    input  logic [W-1:0]  in_d1,
    input  logic [W-1:0]  in_d2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_r0,
    output logic [W-1:0]  out_r1,
    output logic [W-1:0]  out_r2,
    output logic          out_err,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_cnt
);

    // One decoded word as held in the output buffer.
    typedef struct packed {
        logic         err;
        logic [W-1:0] r2;
        logic [W-1:0] r1;
        logic [W-1:0] r0;
    } word_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    word_t dec_word;
    word_t main_word;
    word_t skid_word;
    logic  main_vld;
    logic  skid_full;
    logic  in_xfer;
    logic  out_xfer;
    logic  main_free;

    // Inverse permutation lookup; every code outside the invertible set decodes to an all-zero error word.
    always_comb begin
        dec_word = '0;
        case ({in_outsel, in_regsel})
            4'b0001: begin
                dec_word.r0 = in_d2;
                dec_word.r1 = in_d0;
                dec_word.r2 = in_d1;
            end
            4'b0010: begin
                dec_word.r0 = in_d1;
                dec_word.r1 = in_d2;
                dec_word.r2 = in_d0;
            end
            4'b0101: begin
                dec_word.r0 = in_d0;
                dec_word.r1 = in_d2;
                dec_word.r2 = in_d1;
            end
            4'b1001: begin
                dec_word.r0 = in_d2;
                dec_word.r1 = in_d1;
                dec_word.r2 = in_d0;
            end
            4'b1101: begin
                dec_word.r0 = in_d1;
                dec_word.r1 = in_d0;
                dec_word.r2 = in_d2;
            end
            4'b0100, 4'b1000, 4'b1100: begin
                dec_word.r0 = in_d0;
                dec_word.r1 = in_d1;
                dec_word.r2 = in_d2;
            end
            // 00,00 broadcast, 00,11 and any regsel[1]=1 with outsel!=00 cannot be inverted.
            default: begin
                dec_word.err = 1'b1;
            end
        endcase
    end

    assign in_ready  = ~skid_full;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_vld & out_ready;
    // Main can take a new word this edge if it is empty or being drained.
    assign main_free = ~main_vld | out_xfer;

    // Main/skid buffer: skid drains into main first so order is preserved.
    always_ff @(posedge CLK) begin
        if (RST) begin
            main_word <= '0;
            main_vld  <= 1'b0;
            skid_word <= '0;
            skid_full <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_full) begin
                    // in_ready was low, so no new word can arrive on this edge.
                    main_word <= skid_word;
                    main_vld  <= 1'b1;
                    skid_full <= 1'b0;
                end else if (in_xfer) begin
                    main_word <= dec_word;
                    main_vld  <= 1'b1;
                end else begin
                    main_vld  <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_word <= dec_word;
                skid_full <= 1'b1;
            end
        end
    end

    // Saturating word and error counters, advanced on input transfers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (in_xfer) begin
            if (word_cnt != CNT_MAX) begin
                word_cnt <= word_cnt + CW'(1);
            end
            if (dec_word.err && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CW'(1);
            end
        end
    end

    assign out_valid = main_vld;
    assign out_r0    = main_word.r0;
    assign out_r1    = main_word.r1;
    assign out_r2    = main_word.r2;
    assign out_err   = main_word.err;

endmodule

// File: tb/tb_scramble_decoder.sv
// Bench for scramble_decoder: directed vectors, a queue-based reference model and literal expectations.
module tb_scramble_decoder;
    localparam int W = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   in_outsel;
    logic [1:0]   in_regsel;
    logic [W-1:0] in_d0, in_d1, in_d2;

    logic         in_ready, out_valid, out_err;
    logic [W-1:0] out_r0, out_r1, out_r2;
    logic [7:0]   word_cnt, err_cnt;

    logic         in_ready2, out_valid2, out_err2;
    logic [W-1:0] out2_r0, out2_r1, out2_r2;
    logic [1:0]   word_cnt2, err_cnt2;

    always #5 CLK = ~CLK;

    scramble_decoder #(.W(W), .CW(8)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_outsel(in_outsel), .in_regsel(in_regsel),
        .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r0(out_r0), .out_r1(out_r1), .out_r2(out_r2), .out_err(out_err),
        .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    scramble_decoder #(.W(W), .CW(2)) dut2 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready2),
        .in_outsel(in_outsel), .in_regsel(in_regsel),
        .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_r0(out2_r0), .out_r1(out2_r1), .out_r2(out2_r2), .out_err(out_err2),
        .word_cnt(word_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   wc, ec, wc2, ec2;
    bit   started = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference decode: r[i] = o[p[i]] for an invertible code, else an all-zero error word.
    function automatic exp_t model_decode(input logic [1:0] os, input logic [1:0] rs,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] o [3];
        int           p [3];
        bit           ok;
        exp_t         e;
        o[0] = a; o[1] = b; o[2] = c;
        p  = '{0, 1, 2};
        ok = 1'b1;
        if (os == 2'd0 && rs == 2'b01)      p = '{2, 0, 1};
        else if (os == 2'd0 && rs == 2'b10) p = '{1, 2, 0};
        else if (os != 2'd0 && rs == 2'b00) p = '{0, 1, 2};
        else if (os != 2'd0 && rs == 2'b01) begin
            if (os == 2'd1)      p = '{0, 2, 1};
            else if (os == 2'd2) p = '{2, 1, 0};
            else                 p = '{1, 0, 2};
        end else ok = 1'b0;
        e.err = !ok;
        e.r0  = ok ? o[p[0]] : '0;
        e.r1  = ok ? o[p[1]] : '0;
        e.r2  = ok ? o[p[2]] : '0;
        return e;
    endfunction

    // Model: output side is a 2-deep queue; ready while fewer than 2 words are held.
    always @(posedge CLK) begin
        exp_t e;
        bit   can_in;
        if (RST) begin
            q.delete();
            wc = 0; ec = 0; wc2 = 0; ec2 = 0;
        end else begin
            can_in = (q.size() < 2);
            if (q.size() > 0 && out_ready) e = q.pop_front();
            if (in_valid && can_in) begin
                e = model_decode(in_outsel, in_regsel, in_d0, in_d1, in_d2);
                q.push_back(e);
                if (wc < 255) wc++;
                if (e.err && ec < 255) ec++;
                if (wc2 < 3) wc2++;
                if (e.err && ec2 < 3) ec2++;
            end
        end
        started = 1'b1;
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge CLK) begin
        if (started) begin
            chk("m_in_ready", in_ready, q.size() < 2);
            chk("m_out_valid", out_valid, q.size() > 0);
            chk("m_word_cnt", word_cnt, wc);
            chk("m_err_cnt", err_cnt, ec);
            chk("m_word_cnt_cw2", word_cnt2, wc2);
            chk("m_err_cnt_cw2", err_cnt2, ec2);
            if (q.size() > 0) begin
                chk("m_out_r0", out_r0, q[0].r0);
                chk("m_out_r1", out_r1, q[0].r1);
                chk("m_out_r2", out_r2, q[0].r2);
                chk("m_out_err", out_err, q[0].err);
            end
        end
    end

    task automatic cyc;
        @(posedge CLK);
        #2;
    endtask

    task automatic put(input bit v, input logic [1:0] os, input logic [1:0] rs,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        in_valid  = v;
        in_outsel = os;
        in_regsel = rs;
        in_d0 = a; in_d1 = b; in_d2 = c;
    endtask

    task automatic chk_out(input string nm, input int a, input int b, input int c);
        chk({nm, "_r0"}, out_r0, a);
        chk({nm, "_r1"}, out_r1, b);
        chk({nm, "_r2"}, out_r2, c);
    endtask

    initial begin
        int sat_exp [5];
        sat_exp = '{1, 2, 3, 3, 3};

        RST = 1'b1; out_ready = 1'b0;
        put(0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        cyc; cyc;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk_out("rst_out", 0, 0, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Single decode, 00,01
        RST = 1'b0; out_ready = 1'b1;
        put(1, 2'd0, 2'd1, 5'd2, 5'd3, 5'd1);
        cyc;
        chk("t1_out_valid", out_valid, 1);
        chk_out("t1_out", 1, 2, 3);
        chk("t1_out_err", out_err, 0);
        chk("t1_word_cnt", word_cnt, 1);

        // Back-to-back codes
        put(1, 2'd0, 2'd2, 5'd3, 5'd1, 5'd2);
        cyc;
        chk_out("t2a_out", 1, 2, 3);
        chk("t2a_in_ready", in_ready, 1);
        put(1, 2'd2, 2'd1, 5'd3, 5'd2, 5'd1);
        cyc;
        chk_out("t2b_out", 1, 2, 3);
        chk("t2b_in_ready", in_ready, 1);
        put(1, 2'd3, 2'd1, 5'd2, 5'd1, 5'd3);
        cyc;
        chk_out("t2c_out", 1, 2, 3);
        chk("t2c_in_ready", in_ready, 1);
        chk("t2c_word_cnt", word_cnt, 4);
        put(0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        cyc;
        chk("t2_drained", out_valid, 0);

        // Backpressure: main, skid, refused third word, ordered drain
        out_ready = 1'b0;
        put(1, 2'd1, 2'd0, 5'd4, 5'd5, 5'd6);
        cyc;
        chk("t3_main_valid", out_valid, 1);
        chk("t3_ready_one", in_ready, 1);
        put(1, 2'd1, 2'd1, 5'd7, 5'd8, 5'd9);
        cyc;
        chk("t3_skid_ready", in_ready, 0);
        chk_out("t3_hold_a", 4, 5, 6);
        put(1, 2'd3, 2'd0, 5'd10, 5'd11, 5'd12);
        cyc;
        chk("t3_refused_ready", in_ready, 0);
        chk("t3_refused_cnt", word_cnt, 6);
        chk_out("t3_hold_b", 4, 5, 6);
        put(0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        out_ready = 1'b1;
        cyc;
        chk("t3_second_valid", out_valid, 1);
        chk_out("t3_second", 7, 9, 8);
        chk("t3_ready_back", in_ready, 1);
        cyc;
        chk("t3_empty", out_valid, 0);

        // Error codes
        RST = 1'b1; cyc; RST = 1'b0;
        put(1, 2'd0, 2'd0, 5'd7, 5'd7, 5'd7);
        cyc;
        chk("t4a_err", out_err, 1);
        chk_out("t4a_out", 0, 0, 0);
        chk("t4a_err_cnt", err_cnt, 1);
        put(1, 2'd1, 2'd3, 5'd4, 5'd5, 5'd6);
        cyc;
        chk("t4b_err", out_err, 1);
        chk_out("t4b_out", 0, 0, 0);
        chk("t4b_err_cnt", err_cnt, 2);
        chk("t4b_word_cnt", word_cnt, 2);
        put(0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        cyc;

        // Saturation of the CW=2 instance
        RST = 1'b1; cyc; RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(1, 2'd0, 2'd3, 5'd1, 5'd1, 5'd1);
            cyc;
            chk("t5_word_cnt_cw2", word_cnt2, sat_exp[k]);
            chk("t5_err_cnt_cw2", err_cnt2, sat_exp[k]);
            chk("t5_word_cnt_cw8", word_cnt, k + 1);
        end
        put(0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        cyc;

        // Reset with both buffer entries full
        out_ready = 1'b0;
        put(1, 2'd1, 2'd0, 5'd1, 5'd2, 5'd3);
        cyc;
        put(1, 2'd1, 2'd0, 5'd4, 5'd5, 5'd6);
        cyc;
        chk("t6_full_ready", in_ready, 0);
        chk("t6_full_valid", out_valid, 1);
        RST = 1'b1; out_ready = 1'b1;
        cyc;
        RST = 1'b0;
        put(0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_word_cnt", word_cnt, 0);
        chk("t6_rst_err_cnt", err_cnt, 0);
        cyc;
        chk("t6_after_valid_a", out_valid, 0);
        chk("t6_after_ready", in_ready, 1);
        cyc;
        chk("t6_after_valid_b", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
